dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store data port.
- Accepts one request at a time over a valid/ready handshake.
- Performs the RV32I sized access (byte, half or word) against internal word-organised storage.
- Returns a sign- or zero-extended load result, or a store acknowledgement, after a fixed configurable latency.
- Holds the response until the initiator takes it. Replaces the zero-wait data memory when wait-state behaviour must be exercised.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of storage; power of two, 4 or more.
- LATENCY, 2: cycles from the request-accept edge to the first cycle resp_valid is high; 1 or more.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  access size and sign, RV32I load/store funct3 encoding.
- req_wdata  in  32  store data; the low bits are used for SB/SH.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  32  load result, already extended; 0 for stores and errors.
- resp_err  out  1  access was rejected.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Storage contents are not reset.
  - Reset mid-transaction aborts it. A store not yet committed is discarded.
- FSM states: IDLE, WAIT, RESP.
- req_ready = 1 only in IDLE.
- IDLE:
  - On req_valid & req_ready, latch we, addr, funct3, wdata and load the counter with LATENCY-1.
  - Go to WAIT if LATENCY > 1, else commit and go to RESP.
- WAIT:
  - Decrement the counter.
  - When the counter is 1, commit on that edge and go to RESP.
- Commit edge:
  - Stores write the selected byte lanes; loads capture the extended data into resp_rdata.
  - resp_err is registered on the same edge.
- RESP:
  - resp_valid = 1. resp_rdata and resp_err stay stable.
  - On resp_ready, go to IDLE and drop resp_valid on the next cycle.
  - A new request is not accepted in the same cycle as the response handshake.
  - Minimum spacing between accepts is LATENCY+1 cycles.
- Latency: resp_valid rises exactly LATENCY cycles after the accept edge.
- Load decode:
  - 000 LB: sign-extend byte addr[1:0].
  - 001 LH: sign-extend half addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Store decode:
  - 000 SB: req_wdata[7:0] to lane addr[1:0].
  - 001 SH: req_wdata[15:0] to half addr[1].
  - 010 SW: full word.
- Word index = addr[log2(DEPTH_WORDS)+1 : 2].
- Error conditions (when checked):
  - funct3 is 011, 110 or 111, or 100/101 with we = 1.
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - addr[31:2] >= DEPTH_WORDS.
- On error: no write, resp_rdata = 0, resp_err = 1. The response still completes normally through RESP.
- Inputs are ignored outside IDLE. Request fields may change freely after the accept.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN.
- Defined: the error conditions above are detected and reported on resp_err, and the write is suppressed.
- Undefined:
  - resp_err is tied to 0.
  - Upper address bits are ignored, so the address wraps modulo DEPTH_WORDS*4.
  - Low address bits are forced to alignment: bit 0 is cleared for half accesses, bits 1:0 for word accesses.
  - Illegal funct3 is treated as LW (load) or SW (store).

Test Plan:
- Reset then SW addr 0x10, data 0xDEADBEEF, LATENCY = 2:
  - req_ready drops the cycle after accept; resp_valid is high exactly 2 cycles after accept; resp_rdata = 0.
  - A following LW 0x10 returns 0xDEADBEEF.
- Sub-word accesses after the SW:
  - SB 0x11 with data 0x80, then LB 0x11 returns 0xFFFFFF80 and LBU 0x11 returns 0x00000080.
  - LH 0x12 returns 0xFFFFDEAD; LW 0x10 returns 0xDEAD80EF.
- Backpressure: hold resp_ready = 0 for 5 cycles after resp_valid.
  - resp_valid, resp_rdata and resp_err stay stable; req_ready stays 0 and a new req_valid is not accepted.
  - After resp_ready, the next accept is possible one cycle later.
- DMEM_ERR_CHECK_EN defined:
  - LW 0x13 gives resp_err = 1 and rdata 0.
  - SW 0x1000 (DEPTH_WORDS = 1024) gives resp_err = 1, and LW 0x0 still returns its previous value.
  - funct3 = 011 gives resp_err = 1.
- Reset mid-WAIT during SW 0x20 data 0x12345678 (LATENCY = 4, rst_n pulsed 2 cycles after accept):
  - Outputs return to reset values immediately; LW 0x20 afterwards returns the old contents.
- LATENCY = 1: LW accepted at edge N gives resp_valid high in the cycle after edge N, with correct data.

Source files
------------

// File: rtl/dmem_if.sv
// dmem_if: load/store data port between core (master) and memory (slave).
// Request channel req_* (valid/ready), response channel resp_* (valid/ready).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory; one sized access per request,
// response after LATENCY cycles. Ports: clk, rst_n, bus (dmem_if.slave).
// Macro DMEM_ERR_CHECK_EN enables access checking and resp_err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [2:0]    f3_q;
  logic [31:0]   wd_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic          commit;
  logic          in_idle;

  logic          s_we;
  logic [31:0]   s_addr;
  logic [2:0]    s_f3;
  logic [31:0]   s_wd;

  logic          sz_b;
  logic          sz_h;
  logic          uns;
  logic          legal;
  logic          err;
  logic [1:0]    lane;
  logic [AW-1:0] idx;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   word;
  logic [7:0]    byte_r;
  logic [15:0]   half_r;
  logic [31:0]   ld;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic          wr_en;

  assign in_idle = (state == IDLE);
  assign accept  = in_idle & bus.req_valid;

  // With LATENCY == 1 the commit happens on the accept edge itself,
  // so the live request fields are used instead of the latched copy.
  assign s_we   = in_idle ? bus.req_we     : we_q;
  assign s_addr = in_idle ? bus.req_addr   : addr_q;
  assign s_f3   = in_idle ? bus.req_funct3 : f3_q;
  assign s_wd   = in_idle ? bus.req_wdata  : wd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            commit   = 1'b1;
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          commit   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sz_b  = 1'b0;
    sz_h  = 1'b0;
    uns   = 1'b0;
    legal = 1'b1;
    case (s_f3)
      3'b000: sz_b = 1'b1;
      3'b001: sz_h = 1'b1;
      3'b010: ;
      3'b100: begin
        sz_b  = 1'b1;
        uns   = 1'b1;
        legal = ~s_we;
      end
      3'b101: begin
        sz_h  = 1'b1;
        uns   = 1'b1;
        legal = ~s_we;
      end
      default: legal = 1'b0;
    endcase
    // Illegal encodings fall back to a full-word access.
    if (!legal) begin
      sz_b = 1'b0;
      sz_h = 1'b0;
      uns  = 1'b0;
    end
  end

`ifdef DMEM_ERR_CHECK_EN
  logic misal;
  logic oob;

  assign misal = (sz_h & s_addr[0])
               | (~sz_b & ~sz_h & (s_addr[1:0] != 2'b00));
  assign oob   = |s_addr[31:AW+2];
  assign err   = ~legal | misal | oob;
  assign lane  = s_addr[1:0];
`else
  logic unused_hi;

  // Upper bits are dropped so the address wraps over the storage.
  assign unused_hi = ^{s_addr[31:AW+2], legal};
  assign err       = 1'b0;
  assign lane      = s_addr[1:0]
                   & (sz_b ? 2'b11 : (sz_h ? 2'b10 : 2'b00));
`endif

  assign idx = s_addr[AW+1:2];

  assign word   = mem[idx];
  assign byte_r = word[8*lane +: 8];
  assign half_r = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld = word;
    unique case (1'b1)
      sz_b:    ld = uns ? {24'd0, byte_r}
                        : {{24{byte_r[7]}}, byte_r};
      sz_h:    ld = uns ? {16'd0, half_r}
                        : {{16{half_r[15]}}, half_r};
      default: ld = word;
    endcase
  end

  always_comb begin
    be = 4'hF;
    wd = s_wd;
    unique case (1'b1)
      sz_b: begin
        be = 4'b0001 << lane;
        wd = {4{s_wd[7:0]}};
      end
      sz_h: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{s_wd[15:0]}};
      end
      default: begin
        be = 4'hF;
        wd = s_wd;
      end
    endcase
  end

  // rst_n gate: a store pending when reset asserts is dropped.
  assign wr_en = commit & rst_n & s_we & ~err;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q   <= bus.req_we;
        addr_q <= bus.req_addr;
        f3_q   <= bus.req_funct3;
        wd_q   <= bus.req_wdata;
        cnt    <= CW'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        rdata_q <= (s_we | err) ? 32'd0 : ld;
        err_q   <= err;
      end
    end
  end

  assign bus.req_ready  = in_idle;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed tests of dmem_responder at LATENCY 2, 4, 1.
// Instances: u0 (L=2), u1 (L=4), u2 (L=1), each on its own dmem_if.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2:0]  rstn;
  logic [2:0]  tv;
  logic [2:0]  twe;
  logic [2:0]  trr;
  logic [31:0] tad [3];
  logic [31:0] twd [3];
  logic [2:0]  tf3 [3];
  logic [2:0]  rv;
  logic [2:0]  rr_;
  logic [2:0]  rerr;
  logic [31:0] rdt [3];

  dmem_if b0 ();
  dmem_if b1 ();
  dmem_if b2 ();

  assign b0.req_valid  = tv[0];
  assign b0.req_we     = twe[0];
  assign b0.req_addr   = tad[0];
  assign b0.req_funct3 = tf3[0];
  assign b0.req_wdata  = twd[0];
  assign b0.resp_ready = trr[0];
  assign rv[0]   = b0.resp_valid;
  assign rr_[0]  = b0.req_ready;
  assign rerr[0] = b0.resp_err;
  assign rdt[0]  = b0.resp_rdata;

  assign b1.req_valid  = tv[1];
  assign b1.req_we     = twe[1];
  assign b1.req_addr   = tad[1];
  assign b1.req_funct3 = tf3[1];
  assign b1.req_wdata  = twd[1];
  assign b1.resp_ready = trr[1];
  assign rv[1]   = b1.resp_valid;
  assign rr_[1]  = b1.req_ready;
  assign rerr[1] = b1.resp_err;
  assign rdt[1]  = b1.resp_rdata;

  assign b2.req_valid  = tv[2];
  assign b2.req_we     = twe[2];
  assign b2.req_addr   = tad[2];
  assign b2.req_funct3 = tf3[2];
  assign b2.req_wdata  = twd[2];
  assign b2.resp_ready = trr[2];
  assign rv[2]   = b2.resp_valid;
  assign rr_[2]  = b2.req_ready;
  assign rerr[2] = b2.resp_err;
  assign rdt[2]  = b2.resp_rdata;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u0 (
    .clk(clk), .rst_n(rstn[0]), .bus(b0.slave));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u1 (
    .clk(clk), .rst_n(rstn[1]), .bus(b1.slave));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u2 (
    .clk(clk), .rst_n(rstn[2]), .bus(b2.slave));

  task automatic xact(
    input  int          s,
    input  logic        we,
    input  logic [31:0] ad,
    input  logic [2:0]  f3,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        er,
    output int          lat,
    output logic        rdy0,
    output logic        rdy1
  );
    @(negedge clk);
    rdy0   = rr_[s];
    tv[s]  = 1'b1;
    twe[s] = we;
    tad[s] = ad;
    tf3[s] = f3;
    twd[s] = wd;
    @(posedge clk);
    #1;
    tv[s]  = 1'b0;
    twe[s] = ~we;
    tad[s] = $urandom;
    tf3[s] = 3'($urandom);
    twd[s] = $urandom;
    lat  = 0;
    rd   = 'x;
    er   = 1'bx;
    rdy1 = 1'bx;
    while (lat < 20 && !(lat > 0 && rv[s])) begin
      @(negedge clk);
      lat++;
      if (lat == 1) rdy1 = rr_[s];
    end
    if (!rv[s]) begin
      checks++;
      errors++;
      $display("FAIL timeout inst%0d addr %h got no resp exp resp", s, ad);
    end else begin
      rd     = rdt[s];
      er     = rerr[s];
      trr[s] = 1'b1;
      @(posedge clk);
      #1;
      trr[s] = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (rr_[s] !== 1'b1) begin
        errors++;
        $display("FAIL rst_ready%0d got %b exp 1", s, rr_[s]);
      end
      checks++;
      if (rv[s] !== 1'b0) begin
        errors++;
        $display("FAIL rst_valid%0d got %b exp 0", s, rv[s]);
      end
      checks++;
      if (rdt[s] !== 32'd0) begin
        errors++;
        $display("FAIL rst_rdata%0d got %h exp 0", s, rdt[s]);
      end
      checks++;
      if (rerr[s] !== 1'b0) begin
        errors++;
        $display("FAIL rst_err%0d got %b exp 0", s, rerr[s]);
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic er, r0, r1;
    int lat;
    xact(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat, r0, r1);
    checks++;
    if (r0 !== 1'b1) begin
      errors++;
      $display("FAIL sw_ready_before got %b exp 1", r0);
    end
    checks++;
    if (r1 !== 1'b0) begin
      errors++;
      $display("FAIL sw_ready_after got %b exp 0", r1);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL sw_latency got %0d exp 2", lat);
    end
    checks++;
    if ({er, rd} !== 33'd0) begin
      errors++;
      $display("FAIL sw_resp got %b/%h exp 0/0", er, rd);
    end
    xact(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat, r0, r1);
    checks++;
    if ({er, rd} !== {1'b0, 32'hDEADBEEF} || lat !== 2) begin
      errors++;
      $display("FAIL lw_10 got %b/%h lat %0d exp 0/deadbeef lat 2",
               er, rd, lat);
    end
  endtask

  task automatic test_subword();
    logic        we_t [13];
    logic [31:0] ad_t [13];
    logic [2:0]  f3_t [13];
    logic [31:0] wd_t [13];
    logic [31:0] ex_t [13];
    logic [31:0] rd;
    logic er, r0, r1;
    int lat;
    we_t = '{1,0,0,0,0,1,1,0,0,1,1,0,0};
    ad_t = '{32'h11, 32'h11, 32'h11, 32'h12, 32'h10,
             32'h14, 32'h16, 32'h14, 32'h16, 32'h14,
             32'h17, 32'h14, 32'h14};
    f3_t = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b010,
             3'b010, 3'b001, 3'b010, 3'b101, 3'b000,
             3'b000, 3'b010, 3'b001};
    wd_t = '{32'h80, 0, 0, 0, 0,
             32'h0, 32'h5555A5A5, 0, 0, 32'h1234567F,
             32'hFFFFFF01, 0, 0};
    ex_t = '{32'h0, 32'hFFFFFF80, 32'h00000080, 32'hFFFFDEAD,
             32'hDEAD80EF, 32'h0, 32'h0, 32'hA5A50000,
             32'h0000A5A5, 32'h0, 32'h0, 32'h01A5007F,
             32'h0000007F};
    for (int i = 0; i < 13; i++) begin
      xact(0, we_t[i], ad_t[i], f3_t[i], wd_t[i], rd, er, lat, r0, r1);
      checks++;
      if ({er, rd} !== {1'b0, ex_t[i]}) begin
        errors++;
        $display("FAIL subword%0d got %b/%h exp 0/%h",
                 i, er, rd, ex_t[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r0v;
    logic e0;
    int bad;
    int n;
    logic [31:0] rd;
    logic er, r0, r1;
    int lat;
    @(negedge clk);
    tv[0] = 1'b1; twe[0] = 1'b0; tad[0] = 32'h10;
    tf3[0] = 3'b010; twd[0] = 32'h0;
    @(posedge clk);
    #1;
    tv[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rv[0] && n < 20);
    checks++;
    if (!rv[0]) begin
      errors++;
      $display("FAIL bp_timeout got no resp exp resp");
    end
    r0v = rdt[0];
    e0  = rerr[0];
    checks++;
    if ({e0, r0v} !== {1'b0, 32'hDEAD80EF}) begin
      errors++;
      $display("FAIL bp_data got %b/%h exp 0/dead80ef", e0, r0v);
    end
    tv[0] = 1'b1; twe[0] = 1'b1; tad[0] = 32'h10;
    tf3[0] = 3'b010; twd[0] = 32'h0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rv[0] !== 1'b1 || rdt[0] !== r0v || rerr[0] !== e0
          || rr_[0] !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_stable got %0d unstable cycles exp 0", bad);
    end
    trr[0] = 1'b1;
    @(posedge clk);
    #1;
    trr[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({rr_[0], rv[0]} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release got rdy %b vld %b exp rdy 1 vld 0",
               rr_[0], rv[0]);
    end
    tv[0] = 1'b0;
    xact(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat, r0, r1);
    checks++;
    if ({er, rd} !== {1'b0, 32'hDEAD80EF}) begin
      errors++;
      $display("FAIL bp_no_store got %b/%h exp 0/dead80ef", er, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic er, r0, r1;
    int lat;
    xact(0, 1'b1, 32'h18, 3'b010, 32'h01020304, rd, er, lat, r0, r1);
    xact(0, 1'b0, 32'h18, 3'b010, 32'h0, rd, er, lat, r0, r1);
    checks++;
    if (r0 !== 1'b1 || lat !== 2) begin
      errors++;
      $display("FAIL b2b_accept got rdy %b lat %0d exp rdy 1 lat 2",
               r0, lat);
    end
    checks++;
    if ({er, rd} !== {1'b0, 32'h01020304}) begin
      errors++;
      $display("FAIL b2b_data got %b/%h exp 0/01020304", er, rd);
    end
  endtask

  task automatic test_errors();
    logic        we_t [9];
    logic [31:0] ad_t [9];
    logic [2:0]  f3_t [9];
    logic [31:0] wd_t [9];
    logic [32:0] ex_t [9];
    logic [31:0] rd;
    logic er, r0, r1;
    int lat;
    we_t = '{1,0,1,0,0,1,0,1,0};
`ifdef DMEM_ERR_CHECK_EN
    ad_t = '{32'h0, 32'h13, 32'h1000, 32'h0, 32'h10,
             32'h11, 32'h10, 32'h10, 32'h10};
    f3_t = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b011,
             3'b001, 3'b010, 3'b100, 3'b010};
    wd_t = '{32'hCAFEF00D, 0, 32'h11111111, 0, 0,
             32'h4444, 0, 32'h0, 0};
    ex_t = '{{1'b0, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0},
             {1'b0, 32'hCAFEF00D}, {1'b1, 32'h0}, {1'b1, 32'h0},
             {1'b0, 32'hDEAD80EF}, {1'b1, 32'h0},
             {1'b0, 32'hDEAD80EF}};
`else
    ad_t = '{32'h0, 32'h13, 32'h1000, 32'h0, 32'h10,
             32'h13, 32'h10, 32'h8, 32'h8};
    f3_t = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b011,
             3'b001, 3'b001, 3'b110, 3'b111};
    wd_t = '{32'hCAFEF00D, 0, 32'h11111111, 0, 0,
             32'h4444, 0, 32'h55667788, 0};
    ex_t = '{{1'b0, 32'h0}, {1'b0, 32'hDEAD80EF}, {1'b0, 32'h0},
             {1'b0, 32'h11111111}, {1'b0, 32'hDEAD80EF},
             {1'b0, 32'h0}, {1'b0, 32'hFFFF80EF}, {1'b0, 32'h0},
             {1'b0, 32'h55667788}};
`endif
    for (int i = 0; i < 9; i++) begin
      xact(0, we_t[i], ad_t[i], f3_t[i], wd_t[i], rd, er, lat, r0, r1);
      checks++;
      if ({er, rd} !== ex_t[i]) begin
        errors++;
        $display("FAIL err%0d got %b/%h exp %b/%h",
                 i, er, rd, ex_t[i][32], ex_t[i][31:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic er, r0, r1;
    int lat;
    xact(1, 1'b1, 32'h20, 3'b010, 32'hA5A5A5A5, rd, er, lat, r0, r1);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL l4_latency got %0d exp 4", lat);
    end
    xact(1, 1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat, r0, r1);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL l4_lw got %h exp a5a5a5a5", rd);
    end
    @(negedge clk);
    tv[1] = 1'b1; twe[1] = 1'b1; tad[1] = 32'h20;
    tf3[1] = 3'b010; twd[1] = 32'h12345678;
    @(posedge clk);
    #1;
    tv[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (rr_[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy got %b exp 0", rr_[1]);
    end
    rstn[1] = 1'b0;
    #1;
    checks++;
    if ({rr_[1], rv[1], rerr[1], rdt[1]} !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL mid_rst got rdy %b vld %b err %b rd %h exp 1 0 0 0",
               rr_[1], rv[1], rerr[1], rdt[1]);
    end
    @(negedge clk);
    @(negedge clk);
    rstn[1] = 1'b1;
    xact(1, 1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat, r0, r1);
    checks++;
    if ({er, rd} !== {1'b0, 32'hA5A5A5A5} || lat !== 4) begin
      errors++;
      $display("FAIL mid_old got %b/%h lat %0d exp 0/a5a5a5a5 lat 4",
               er, rd, lat);
    end
  endtask

  task automatic test_latency1();
    logic [31:0] rd;
    logic er, r0, r1;
    int lat;
    xact(2, 1'b1, 32'h40, 3'b010, 32'h0BADCAFE, rd, er, lat, r0, r1);
    checks++;
    if (lat !== 1 || r1 !== 1'b0) begin
      errors++;
      $display("FAIL l1_sw got lat %0d rdy %b exp lat 1 rdy 0", lat, r1);
    end
    xact(2, 1'b0, 32'h40, 3'b010, 32'h0, rd, er, lat, r0, r1);
    checks++;
    if ({er, rd} !== {1'b0, 32'h0BADCAFE} || lat !== 1 || r0 !== 1'b1) begin
      errors++;
      $display("FAIL l1_lw got %b/%h lat %0d exp 0/0badcafe lat 1",
               er, rd, lat);
    end
    xact(2, 1'b0, 32'h43, 3'b100, 32'h0, rd, er, lat, r0, r1);
    checks++;
    if ({er, rd} !== {1'b0, 32'h0000000B}) begin
      errors++;
      $display("FAIL l1_lbu got %b/%h exp 0/0000000b", er, rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    rstn = 3'b000;
    tv   = '0;
    twe  = '0;
    trr  = '0;
    for (int i = 0; i < 3; i++) begin
      tad[i] = '0;
      twd[i] = '0;
      tf3[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rstn = 3'b111;
    test_store_load();
    test_subword();
    test_backpressure();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
